// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and default sizes for the parametrised register file
package rf_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W_DEF = 8;
    localparam int RF_ADDR_W_DEF = 3;

endpackage

// File: rtl/param_register_file_if.sv
// rtl/param_register_file_if.sv - write, clear, sweep and dual-read bus of the register file
interface param_register_file_if #(
    parameter int DATA_W = rf_pkg::RF_DATA_W_DEF,
    parameter int ADDR_W = rf_pkg::RF_ADDR_W_DEF
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              clr_en;
    logic              clr_all;
    logic              busy;
    logic              sweep_done;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;

    modport master (
        output wr_en, wr_addr, wr_data, clr_en, clr_all, addr_a, addr_b,
        input  wr_ready, busy, sweep_done, val_a, val_b
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clr_en, clr_all, addr_a, addr_b,
        output wr_ready, busy, sweep_done, val_a, val_b
    );
endinterface

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port: array mux, write forwarding,
// zero-register and sweep masking.
module rf_read_port #(
    parameter int DATA_W   = rf_pkg::RF_DATA_W_DEF,
    parameter int ADDR_W   = rf_pkg::RF_ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic [DATA_W-1:0] mem [2**ADDR_W],
    input  logic [ADDR_W-1:0] addr,
    input  logic              busy,
    input  logic              wr_en,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rdata
);
    // Later assignments take priority: busy masking beats everything else.
    always_comb begin
        rdata = mem[addr];
        if ((BYPASS != 0) && wr_en && (wr_addr == addr)) begin
            rdata = clr_en ? '0 : wr_data;
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            rdata = '0;
        end
        if (busy) begin
            rdata = '0;
        end
    end
endmodule

// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - 2-read/1-write register file with per-register clear
// and a multi-cycle clear-all sweep.
module param_register_file
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input logic                  clk,
    input logic                  reset,
    param_register_file_if.slave rf
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy;

    assign busy          = (state_q == RF_SWEEP);
    assign rf.busy       = busy;
    assign rf.wr_ready   = ~busy;
    assign rf.sweep_done = busy && (&idx_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mem_d   = mem_q;
        case (state_q)
            RF_IDLE: begin
                // clr_all beats clr_en, which beats a plain write.
                if (rf.clr_all) begin
                    state_d  = RF_SWEEP;
                    mem_d[0] = '0;
                    idx_d    = ADDR_W'(1);
                end else if (rf.clr_en) begin
                    mem_d[rf.wr_addr] = '0;
                end else if (rf.wr_en) begin
                    mem_d[rf.wr_addr] = rf.wr_data;
                end
            end
            RF_SWEEP: begin
                mem_d[idx_q] = '0;
                idx_d        = idx_q + ADDR_W'(1);
                if (&idx_q) begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                state_d = RF_IDLE;
            end
        endcase
        if (ZERO_REG != 0) begin
            mem_d[0] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RF_IDLE;
            idx_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mem_q   <= mem_d;
        end
    end

    rf_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_REG(ZERO_REG)
    ) u_port_a (
        .mem    (mem_q),
        .addr   (rf.addr_a),
        .busy   (busy),
        .wr_en  (rf.wr_en),
        .clr_en (rf.clr_en),
        .wr_addr(rf.wr_addr),
        .wr_data(rf.wr_data),
        .rdata  (rf.val_a)
    );

    rf_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_REG(ZERO_REG)
    ) u_port_b (
        .mem    (mem_q),
        .addr   (rf.addr_b),
        .busy   (busy),
        .wr_en  (rf.wr_en),
        .clr_en (rf.clr_en),
        .wr_addr(rf.wr_addr),
        .wr_data(rf.wr_data),
        .rdata  (rf.val_b)
    );
endmodule

// File: tb/tb_param_register_file.sv
// tb/tb_param_register_file.sv - bench for param_register_file in three configurations
// (8x8 with and without bypass sharing one stimulus, and a 16x16 zero-register file).
module tb_param_register_file;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    logic       s_wr_en = 0, s_clr_en = 0, s_clr_all = 0;
    logic [2:0] s_wr_addr = 0, s_addr_a = 0, s_addr_b = 0;
    logic [7:0] s_wr_data = 0;

    logic        z_wr_en = 0, z_clr_en = 0, z_clr_all = 0;
    logic [3:0]  z_wr_addr = 0, z_addr_a = 0, z_addr_b = 0;
    logic [15:0] z_wr_data = 0;

    param_register_file_if #(.DATA_W(8),  .ADDR_W(3)) if_b1 ();
    param_register_file_if #(.DATA_W(8),  .ADDR_W(3)) if_b0 ();
    param_register_file_if #(.DATA_W(16), .ADDR_W(4)) if_z ();

    assign if_b1.wr_en = s_wr_en;   assign if_b0.wr_en = s_wr_en;
    assign if_b1.wr_addr = s_wr_addr; assign if_b0.wr_addr = s_wr_addr;
    assign if_b1.wr_data = s_wr_data; assign if_b0.wr_data = s_wr_data;
    assign if_b1.clr_en = s_clr_en; assign if_b0.clr_en = s_clr_en;
    assign if_b1.clr_all = s_clr_all; assign if_b0.clr_all = s_clr_all;
    assign if_b1.addr_a = s_addr_a; assign if_b0.addr_a = s_addr_a;
    assign if_b1.addr_b = s_addr_b; assign if_b0.addr_b = s_addr_b;

    assign if_z.wr_en = z_wr_en;
    assign if_z.wr_addr = z_wr_addr;
    assign if_z.wr_data = z_wr_data;
    assign if_z.clr_en = z_clr_en;
    assign if_z.clr_all = z_clr_all;
    assign if_z.addr_a = z_addr_a;
    assign if_z.addr_b = z_addr_b;

    param_register_file #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0))
        dut_b1 (.clk(clk), .reset(reset), .rf(if_b1));
    param_register_file #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0))
        dut_b0 (.clk(clk), .reset(reset), .rf(if_b0));
    param_register_file #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(1))
        dut_z (.clk(clk), .reset(reset), .rf(if_z));

    // Behavioural model: a clear-all zeroes everything at once and then just
    // counts down the busy cycles, since nothing is visible or writable meanwhile.
    logic [7:0]  m8 [8];
    logic [15:0] m16 [16];
    int left8 = 0;
    int left16 = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            foreach (m8[i]) m8[i] = 8'h00;
            foreach (m16[i]) m16[i] = 16'h0000;
            left8 = 0;
            left16 = 0;
        end else begin
            if (left8 > 0) left8--;
            else if (s_clr_all) begin
                foreach (m8[i]) m8[i] = 8'h00;
                left8 = 7;
            end else if (s_clr_en) m8[s_wr_addr] = 8'h00;
            else if (s_wr_en) m8[s_wr_addr] = s_wr_data;

            if (left16 > 0) left16--;
            else if (z_clr_all) begin
                foreach (m16[i]) m16[i] = 16'h0000;
                left16 = 15;
            end else if (z_clr_en) begin
                if (z_wr_addr != 0) m16[z_wr_addr] = 16'h0000;
            end else if (z_wr_en && z_wr_addr != 0) m16[z_wr_addr] = z_wr_data;
        end
    end

    function automatic logic [7:0] exp8(input logic [2:0] a, input bit byp);
        if (left8 > 0) return 8'h00;
        if (byp && s_wr_en && s_wr_addr == a) return s_clr_en ? 8'h00 : s_wr_data;
        return m8[a];
    endfunction

    function automatic logic [15:0] exp16(input logic [3:0] a);
        if (left16 > 0 || a == 0) return 16'h0000;
        if (z_wr_en && z_wr_addr == a) return z_clr_en ? 16'h0000 : z_wr_data;
        return m16[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("b1_val_a", 32'(if_b1.val_a), 32'(exp8(s_addr_a, 1'b1)));
            check("b1_val_b", 32'(if_b1.val_b), 32'(exp8(s_addr_b, 1'b1)));
            check("b0_val_a", 32'(if_b0.val_a), 32'(exp8(s_addr_a, 1'b0)));
            check("b0_val_b", 32'(if_b0.val_b), 32'(exp8(s_addr_b, 1'b0)));
            check("b1_busy", 32'(if_b1.busy), 32'(left8 > 0));
            check("b0_busy", 32'(if_b0.busy), 32'(left8 > 0));
            check("b1_wr_ready", 32'(if_b1.wr_ready), 32'(left8 == 0));
            check("b1_sweep_done", 32'(if_b1.sweep_done), 32'(left8 == 1));
            check("b0_sweep_done", 32'(if_b0.sweep_done), 32'(left8 == 1));
            check("z_val_a", 32'(if_z.val_a), 32'(exp16(z_addr_a)));
            check("z_val_b", 32'(if_z.val_b), 32'(exp16(z_addr_b)));
            check("z_busy", 32'(if_z.busy), 32'(left16 > 0));
            check("z_wr_ready", 32'(if_z.wr_ready), 32'(left16 == 0));
            check("z_sweep_done", 32'(if_z.sweep_done), 32'(left16 == 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write8(input logic [2:0] a, input logic [7:0] d);
        s_wr_en = 1; s_wr_addr = a; s_wr_data = d;
        step();
        s_wr_en = 0;
    endtask

    // Pulse clr_all, then follow busy for a bounded number of cycles.
    task automatic sweep8(input int hit_cycle, output int n, output int pulses);
        s_clr_all = 1;
        step();
        s_clr_all = 0;
        n = 0;
        pulses = 0;
        while (if_b1.busy && n < 40) begin
            if (if_b1.sweep_done) pulses++;
            if (n == hit_cycle) begin
                s_wr_en = 1; s_wr_addr = 3'd6; s_wr_data = 8'h55;
                #1 check("sweep_wr_ready_low", 32'(if_b1.wr_ready), 32'd0);
            end
            step();
            s_wr_en = 0;
            n++;
        end
    endtask

    int n, pulses;

    initial begin
        s_addr_a = 3'd3; s_addr_b = 3'd7;
        z_addr_a = 4'd3; z_addr_b = 4'd7;
        #2 reset = 1;
        #1;
        check("rst_val_a", 32'(if_b1.val_a), 32'h0);
        check("rst_val_b", 32'(if_b1.val_b), 32'h0);
        check("rst_busy", 32'(if_b1.busy), 32'h0);
        check("rst_wr_ready", 32'(if_b1.wr_ready), 32'h1);
        check("rst_z_val_b", 32'(if_z.val_b), 32'h0);
        cmp_on = 1;
        step();
        reset = 0;
        step();

        // Same-cycle write forwarding vs. no forwarding.
        s_addr_a = 3'd2;
        s_wr_en = 1; s_wr_addr = 3'd2; s_wr_data = 8'hA5;
        #1;
        check("bypass1_same_cycle", 32'(if_b1.val_a), 32'hA5);
        check("bypass0_same_cycle", 32'(if_b0.val_a), 32'h00);
        step();
        s_wr_en = 0;
        #1 check("bypass0_next_cycle", 32'(if_b0.val_a), 32'hA5);

        // Clear beats write on the same address.
        write8(3'd4, 8'h3C);
        s_addr_a = 3'd4;
        s_clr_en = 1; s_wr_en = 1; s_wr_addr = 3'd4; s_wr_data = 8'hFF;
        #1;
        check("clr_prio_b1_during", 32'(if_b1.val_a), 32'h00);
        check("clr_prio_b0_during", 32'(if_b0.val_a), 32'h3C);
        step();
        s_clr_en = 0; s_wr_en = 0;
        #1;
        check("clr_prio_b1_after", 32'(if_b1.val_a), 32'h00);
        check("clr_prio_b0_after", 32'(if_b0.val_a), 32'h00);
        check("model_m8_4", 32'(m8[4]), 32'h00);

        // Full sweep with a dropped write mid-sweep.
        for (int i = 0; i < 8; i++) write8(3'(i), 8'(8'h11 * (i + 1)));
        s_addr_a = 3'd6; s_addr_b = 3'd5;
        #1 check("prefill_addr6", 32'(if_b1.val_a), 32'h77);
        sweep8(2, n, pulses);
        check("sweep_busy_cycles", 32'(n), 32'd7);
        check("sweep_done_pulses", 32'(pulses), 32'd1);
        #1;
        check("sweep_addr6_after", 32'(if_b1.val_a), 32'h00);
        check("sweep_addr5_after", 32'(if_b0.val_b), 32'h00);

        // Reset on the third busy cycle, then a fresh full sweep.
        write8(3'd1, 8'h9A);
        write8(3'd5, 8'h6B);
        s_clr_all = 1;
        step();
        s_clr_all = 0;
        step();
        step();
        #2 reset = 1;
        #1 check("midsweep_rst_busy", 32'(if_b1.busy), 32'd0);
        step();
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            s_addr_a = 3'(i);
            #1 check("post_rst_zero", 32'(if_b1.val_a), 32'h00);
        end
        sweep8(-1, n, pulses);
        check("fresh_sweep_cycles", 32'(n), 32'd7);
        check("fresh_sweep_pulses", 32'(pulses), 32'd1);

        // Zero register, 16-bit data, 16-entry sweep.
        z_addr_a = 4'd0; z_addr_b = 4'd15;
        z_wr_en = 1; z_wr_addr = 4'd0; z_wr_data = 16'hBEEF;
        #1;
        check("zero_bypass", 32'(if_z.val_a), 32'h0);
        check("zero_wr_ready", 32'(if_z.wr_ready), 32'h1);
        step();
        z_wr_addr = 4'd15; z_wr_data = 16'h1234;
        #1 check("z15_bypass", 32'(if_z.val_b), 32'h1234);
        step();
        z_wr_en = 0;
        #1;
        check("zero_after", 32'(if_z.val_a), 32'h0);
        check("z15_after", 32'(if_z.val_b), 32'h1234);
        z_clr_all = 1;
        step();
        z_clr_all = 0;
        n = 0;
        while (if_z.busy && n < 40) begin
            step();
            n++;
        end
        check("z_sweep_cycles", 32'(n), 32'd15);
        #1 check("z15_after_sweep", 32'(if_z.val_b), 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised 2-read/1-write register file for the single-cycle datapath; successor to the fixed 8x8 file.
- Adds configurable width and depth, write-to-read bypass, an optional hard-wired zero register, a per-register synchronous clear, and a multi-cycle clear-all sweep with a busy/ready handshake.
- Sits between the decode stage (addresses) and the ALU (operand buses A/B), with the writeback stage driving the write port.

Parameters:
- DATA_W, 8: register width in bits.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W registers.
- BYPASS, 1: 1 = a same-cycle write to a read address is forwarded to that read port.
- ZERO_REG, 0: 1 = register 0 always reads 0 and ignores writes and clears.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all storage and the FSM.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  write accepted this cycle; equals not busy.
- clr_en  in  1  synchronous clear of register wr_addr.
- clr_all  in  1  start a clear-all sweep (single-cycle pulse).
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse on the final sweep cycle.
- addr_a  in  ADDR_W  read address, port A.
- addr_b  in  ADDR_W  read address, port B.
- val_a  out  DATA_W  read data, port A (combinational).
- val_b  out  DATA_W  read data, port B (combinational).

Behaviour:
- Reset (async):
  - All registers 0; FSM to IDLE; sweep index 0.
  - busy=0, sweep_done=0, wr_ready=1.
  - val_a/val_b therefore read 0.
- Write:
  - Happens on the rising edge when wr_en and wr_ready are both high.
  - If wr_en is high while busy, the write is dropped with no side effect. The source must hold the request until wr_ready is high.
- Per-register clear:
  - clr_en clears register wr_addr on the edge.
  - If clr_en and wr_en target the same cycle, clr_en wins and wr_data is discarded.
  - clr_en is ignored while busy, since the sweep covers it.
- Reads:
  - Combinational, zero latency.
  - While busy, val_a and val_b are forced to 0, so partially cleared contents are never visible.
- Bypass (BYPASS=1, not busy, wr_en high, clr_en low, wr_addr equal to the read address):
  - The port outputs wr_data in the same cycle.
  - If clr_en is high for that address, the port outputs 0.
  - BYPASS=0: the port shows the old value until after the edge.
- Zero register (ZERO_REG=1):
  - addr 0 always reads 0, including under bypass.
  - Writes and clears to addr 0 are no-ops, but wr_ready still reports acceptance.
- FSM states are IDLE and SWEEP.
  - IDLE -> SWEEP on clr_all. That same edge clears register 0 and sets index to 1; busy goes high the next cycle.
  - In SWEEP, each edge clears register[index] and increments index.
  - sweep_done=1 during the cycle in which index = DEPTH-1. On that edge the last register is cleared, index wraps to 0, and the FSM returns to IDLE.
  - Total busy duration is DEPTH-1 cycles; the sweep is complete DEPTH edges after clr_all is sampled.
  - clr_all while in SWEEP is ignored (no restart).
  - clr_all together with wr_en in IDLE: the clear-all wins and the write is dropped; wr_ready is high that cycle but the data is lost. The writeback stage must not issue both together.
  - Async reset mid-sweep: immediate IDLE, all registers 0.
- Width rules:
  - The index counter is ADDR_W bits and wraps naturally.
  - No arithmetic is performed on data.

Decomposition:
- Shared package rf_pkg:
  - FSM state encoding (RF_IDLE=0, RF_SWEEP=1).
  - Default DATA_W/ADDR_W constants reused by the datapath.
- One natural sub-module, rf_read_port: combinational mux plus bypass/zero/busy masking.
  - Instantiated twice, for A and B.
  - The storage array and FSM stay in the top module.

Test Plan:
- Reset then read: assert reset mid-cycle, addr_a=3, addr_b=7 -> val_a=val_b=0 immediately; busy=0, wr_ready=1.
- Write/read, bypass: write 0xA5 to addr 2 with addr_a=2 -> BYPASS=1 gives val_a=0xA5 in the same cycle; BYPASS=0 gives 0x00, then 0xA5 the next cycle.
- Clear priority: preload addr 4 = 0x3C; in one cycle clr_en=1, wr_en=1, wr_addr=4, wr_data=0xFF -> addr 4 reads 0x00 afterwards and val_a (addr_a=4) reads 0 during the cycle.
- Sweep: fill all 8 registers with 0x11..0x88, pulse clr_all -> busy high for 7 cycles, sweep_done one pulse, reads 0 throughout; a wr_en of 0x55 to addr 6 mid-sweep sees wr_ready=0 and addr 6 reads 0 after the sweep.
- Reset mid-sweep: assert reset on the 3rd busy cycle -> busy=0 immediately, all registers 0, a following clr_all starts a fresh full sweep.
- ZERO_REG=1, ADDR_W=4, DATA_W=16: write 0xBEEF to addr 0 and 0x1234 to addr 15 -> addr 0 reads 0 (bypass included), addr 15 reads 0x1234; a sweep takes 16 edges.
